// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU fetch slice.
//   - NOP encoding and default HALT opcode
//   - fetch FSM state enum {RUN, HALT}
//   - IF/ID pipeline register struct
//   - address-width helper derived from memory depth
//   - saturating 16-bit increment helper
package cpu_pkg;

  localparam logic [15:0] NOP             = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE_DEF = 4'hF;
  localparam int          MEM_DEPTH_DEF   = 64;

  // Significant PC bits for a given memory depth (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  localparam int ADDR_W = addr_w(MEM_DEPTH_DEF);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // IF/ID pipeline register contents.
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_plus1;
    logic        valid;
  } ifid_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// Instruction read port between the fetch stage and CPU memory.
//   i_addr : instruction word address (fetch -> memory)
//   re_0   : instruction read enable   (fetch -> memory)
//   instr  : combinational read data   (memory -> fetch)
// Modports: master = fetch stage, slave = memory.
interface cpu_fetch_if;
  logic [15:0] i_addr;
  logic        re_0;
  logic [15:0] instr;

  modport master (output i_addr, output re_0, input instr);
  modport slave  (input i_addr, input re_0, output instr);
endinterface

// File: rtl/cpu_fetch.sv
// Instruction-fetch stage.
// Holds the PC, drives the memory instruction port and captures the returned
// word into the IF/ID register. Handles stall, branch flush/redirect, HALT
// detection and a saturating count of valid captures.
// Ports:
//   clk, rst_n        : clock (rising edge), async active-low reset
//   stall             : freeze PC, IF/ID, state and counter
//   flush             : squash IF/ID, redirect PC to branch_target
//   branch_target     : redirect address (low log2(MEM_DEPTH) bits used)
//   imem              : memory instruction port (i_addr, re_0, instr)
//   if_instr/if_pc/if_pc_plus1/if_valid : IF/ID register
//   halted            : fetch FSM is in HALT
//   fetch_cnt         : saturating count of valid captures
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int          MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic [15:0]        branch_target,
  cpu_fetch_if.master        imem,
  output logic [15:0]        if_instr,
  output logic [15:0]        if_pc,
  output logic [15:0]        if_pc_plus1,
  output logic               if_valid,
  output logic               halted,
  output logic [15:0]        fetch_cnt
);

  localparam int AW = addr_w(MEM_DEPTH);
  localparam logic [AW-1:0] PC_LAST = AW'(MEM_DEPTH - 1);

  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, pc_inc;
  logic [15:0]   pc_ext, inc_ext;
  ifid_t         ifid_q, ifid_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          is_halt;

  // PC keeps only the significant bits; explicit wrap also covers
  // non-power-of-two depths.
  assign pc_inc  = (pc_q == PC_LAST) ? '0 : pc_q + AW'(1);
  assign pc_ext  = {{(16-AW){1'b0}}, pc_q};
  assign inc_ext = {{(16-AW){1'b0}}, pc_inc};
  assign is_halt = (imem.instr[15:12] == HALT_OPCODE);

  // Next-state: flush beats stall beats normal progress.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      // Redirect also leaves HALT, so a HALT fetched in a branch shadow
      // never sticks.
      pc_d         = branch_target[AW-1:0];
      ifid_d.valid = 1'b0;
      ifid_d.instr = NOP;
      state_d      = RUN;
    end else if (!stall) begin
      unique case (state_q)
        RUN: begin
          ifid_d.instr    = imem.instr;
          ifid_d.pc       = pc_ext;
          ifid_d.pc_plus1 = inc_ext;
          ifid_d.valid    = 1'b1;
          cnt_d           = sat_inc16(cnt_q);
          // The HALT word itself is passed down; PC parks on it.
          if (is_halt) state_d = HALT;
          else         pc_d    = pc_inc;
        end
        HALT: begin
          ifid_d.valid = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC[AW-1:0];
      ifid_q  <= '{instr: NOP, pc: 16'h0000, pc_plus1: 16'h0000, valid: 1'b0};
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem.i_addr = pc_ext;
  assign imem.re_0   = (state_q == RUN) && !stall;
  assign if_instr    = ifid_q.instr;
  assign if_pc       = ifid_q.pc;
  assign if_pc_plus1 = ifid_q.pc_plus1;
  assign if_valid    = ifid_q.valid;
  assign halted      = (state_q == HALT);
  assign fetch_cnt   = cnt_q;

endmodule

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Instruction-fetch stage directly upstream of the CPU memory's instruction read port.
- Holds the PC and drives the memory's instruction address and instruction read enable.
- Captures the returned 16-bit instruction into the IF/ID pipeline register for decode.
- Handles stall, branch flush/redirect, HALT detection, and a saturating fetch counter.

Parameters:
- MEM_DEPTH, 64: instruction/data memory depth in 16-bit words; PC wraps modulo this value.
- RESET_PC, 16'h0000: PC value loaded on reset.
- HALT_OPCODE, 4'hF: value of instr[15:12] that marks a HALT instruction.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall from decode; freezes PC and IF/ID.
- flush  in  1  branch taken; squashes IF/ID and redirects the PC.
- branch_target  in  16  redirect address; valid when flush=1.
- instr  in  16  combinational instruction word returned by memory for i_addr.
- i_addr  out  16  instruction address to memory; equals PC.
- re_0  out  1  instruction read enable.
- if_instr  out  16  IF/ID instruction.
- if_pc  out  16  IF/ID PC of if_instr.
- if_pc_plus1  out  16  IF/ID PC+1, modulo MEM_DEPTH.
- if_valid  out  1  IF/ID contents valid.
- halted  out  1  fetch is in the HALT state.
- fetch_cnt  out  16  count of valid captures; saturates.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC; if_instr=16'h0000 (NOP); if_pc=0; if_pc_plus1=0; if_valid=0.
  - state=RUN; halted=0; fetch_cnt=0.
- States: RUN, HALT. halted = (state==HALT).
- Outputs:
  - i_addr = pc, combinational.
  - re_0 = (state==RUN) & ~stall.
- PC width rule: PC holds log2(MEM_DEPTH) significant bits; upper bits are always 0.
  - pc+1 wraps MEM_DEPTH-1 -> 0.
  - branch_target is truncated to the low log2(MEM_DEPTH) bits.
- Per-edge priority: flush > stall > normal.
  - flush=1, any state: pc<=branch_target; if_valid<=0; if_instr<=NOP; state<=RUN. fetch_cnt unchanged. This squashes a HALT fetched in a branch shadow.
  - stall=1, flush=0: pc, IF/ID, state and fetch_cnt all hold.
  - RUN normal:
    - if_instr<=instr; if_pc<=pc; if_pc_plus1<=pc+1.
    - if_valid<=1; pc<=pc+1; fetch_cnt<=sat(fetch_cnt+1).
    - If instr[15:12]==HALT_OPCODE: state<=HALT and pc holds instead of incrementing. The HALT instruction itself is passed with if_valid=1.
  - HALT normal: if_valid<=0; pc holds; IF/ID data holds.
- Latency: the word at address A is on if_instr one cycle after the edge where pc==A in RUN without stall.
- Throughput: one instruction per cycle.
- fetch_cnt saturates at 16'hFFFF; it is not reset by flush.
- Reset asserted mid-operation returns everything to reset values immediately; no partial capture.

Decomposition:
- Shared package cpu_pkg:
  - NOP encoding 16'h0000, HALT_OPCODE, fetch state enum {RUN, HALT}.
  - Address-width constant derived from MEM_DEPTH (log2).
- Single module; no sub-module is natural. Next-PC mux and saturating counter stay inline.

Test Plan:
- Reset then run, memory [0]=1234, [1]=5678, [2]=9ABC -> if_instr 1234/5678/9ABC on cycles 1/2/3; if_pc 0/1/2; if_valid=1; fetch_cnt=3.
- stall high 2 cycles while pc=2 -> i_addr stays 2; re_0=0; if_instr/if_pc/fetch_cnt frozen; resumes with [2] after release.
- flush with branch_target=16'h0028 at pc=5, stall also high -> next cycle pc=0x28, if_valid=0, if_instr=0000; then [0x28] captured.
- Word F000 at address 7 -> captured with if_valid=1, halted=1 next cycle, pc stays 7, if_valid=0 thereafter; later flush to 0x10 -> halted=0 and fetch restarts at 0x10.
- pc=63 (MEM_DEPTH-1) normal fetch -> if_pc_plus1=0 and pc=0 next; branch_target=16'h0047 -> pc=0x07.
- Preload fetch_cnt path to FFFE, fetch 3 instructions -> FFFF, stays FFFF; async rst_n low mid-cycle -> all outputs 0 / RESET_PC immediately.
